// File: rtl/dram_sched.sv
// rtl/dram_sched.sv - shared DRAM sequencer for video, sound and CPU with fixed-priority arbitration
// Optional CAS-before-RAS refresh generator is compiled in with DRAM_REFRESH_EN.
module dram_sched #(
    parameter int PRE_CYCLES   = 2,
    parameter int CPU_MAX_WAIT = 2,
    parameter int REFRESH_DIV  = 256
) (
    input  logic       clk,
    input  logic       n_res,
    input  logic       vid_req,
    input  logic       snd_req,
    input  logic       cpu_req,
    input  logic       cpu_rw,
    output logic       vid_ack,
    output logic       snd_ack,
    output logic       cpu_ack,
    output logic       n_ras,
    output logic       n_cas,
    output logic       row_col,
    output logic [1:0] addr_sel,
    output logic       n_we,
    output logic       n_buf_oe,
    output logic       buf_dir,
    output logic       n_vid_ld,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAS     = 3'd1,
        MUX     = 3'd2,
        CAS     = 3'd3,
        PRE     = 3'd4
`ifdef DRAM_REFRESH_EN
        , CBR_CAS = 3'd5,
        CBR_RAS = 3'd6
`endif
    } state_t;

    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_VID = 2'd1,
        OWN_SND = 2'd2,
        OWN_REF = 2'd3
    } owner_t;

    localparam logic [1:0] LOSE_MAX = 2'(CPU_MAX_WAIT);
    localparam logic [1:0] PRE_LAST = 2'(PRE_CYCLES - 1);

    if (PRE_CYCLES < 1 || PRE_CYCLES > 3 || CPU_MAX_WAIT < 1 || CPU_MAX_WAIT > 3 ||
        REFRESH_DIV < 2) begin : g_bad_param
        $error("dram_sched: parameter out of range");
    end

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic       rw_q, rw_d;
    logic [1:0] lose_q, lose_d;
    logic [1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0] addr_sel_q, addr_sel_d;
    logic       vid_ack_q, vid_ack_d, snd_ack_q, snd_ack_d, cpu_ack_q, cpu_ack_d;
    logic       n_ras_q, n_ras_d, n_cas_q, n_cas_d, row_col_q, row_col_d;
    logic       n_we_q, n_we_d, n_buf_oe_q, n_buf_oe_d, buf_dir_q, buf_dir_d;
    logic       n_vid_ld_q, n_vid_ld_d, busy_q, busy_d;
    logic       grant;

`ifdef DRAM_REFRESH_EN
    localparam int DIV_W = $clog2(REFRESH_DIV);
    logic [DIV_W-1:0] div_q, div_d;
    logic             ref_pend_q, ref_pend_d;

    // Divider is frozen while a refresh is pending and restarts when it is granted.
    always_comb begin
        div_d      = div_q;
        ref_pend_d = ref_pend_q;
        if (state_q == IDLE && ref_pend_q) begin
            ref_pend_d = 1'b0;
            div_d      = '0;
        end else if (!ref_pend_q) begin
            if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
                ref_pend_d = 1'b1;
                div_d      = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        lose_d     = lose_q;
        pre_cnt_d  = pre_cnt_q;
        addr_sel_d = addr_sel_q;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef DRAM_REFRESH_EN
                if (ref_pend_q) begin
                    grant   = 1'b1;
                    owner_d = OWN_REF;
                end else
`endif
                if (cpu_req && lose_q == LOSE_MAX) begin
                    grant   = 1'b1;
                    owner_d = OWN_CPU;
                end else if (vid_req) begin
                    grant   = 1'b1;
                    owner_d = OWN_VID;
                end else if (snd_req) begin
                    grant   = 1'b1;
                    owner_d = OWN_SND;
                end else if (cpu_req) begin
                    grant   = 1'b1;
                    owner_d = OWN_CPU;
                end
                if (grant) begin
                    rw_d = cpu_rw;
`ifdef DRAM_REFRESH_EN
                    if (owner_d == OWN_REF) state_d = CBR_CAS;
                    else
`endif
                    begin
                        state_d    = RAS;
                        addr_sel_d = owner_d;
                    end
                end
                // Lose counter saturates at the forcing threshold.
                if (!cpu_req || (grant && owner_d == OWN_CPU)) lose_d = '0;
                else if (grant && lose_q != LOSE_MAX) lose_d = lose_q + 2'd1;
            end
            RAS: state_d = MUX;
            MUX: state_d = CAS;
            CAS: begin
                state_d   = PRE;
                pre_cnt_d = '0;
            end
            PRE: begin
                if (pre_cnt_q == PRE_LAST) state_d = IDLE;
                else pre_cnt_d = pre_cnt_q + 2'd1;
            end
`ifdef DRAM_REFRESH_EN
            CBR_CAS: state_d = CBR_RAS;
            CBR_RAS: begin
                state_d   = PRE;
                pre_cnt_d = '0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        vid_ack_d  = 1'b0;
        snd_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        n_ras_d    = 1'b1;
        n_cas_d    = 1'b1;
        row_col_d  = 1'b0;
        n_we_d     = 1'b1;
        n_buf_oe_d = 1'b1;
        n_vid_ld_d = 1'b1;
        case (state_d)
            RAS: n_ras_d = 1'b0;
            MUX: begin
                n_ras_d   = 1'b0;
                row_col_d = 1'b1;
                if (owner_d == OWN_CPU) begin
                    n_buf_oe_d = 1'b0;
                    n_we_d     = rw_d;
                end
            end
            CAS: begin
                n_ras_d   = 1'b0;
                n_cas_d   = 1'b0;
                row_col_d = 1'b1;
                vid_ack_d = (owner_d == OWN_VID);
                snd_ack_d = (owner_d == OWN_SND);
                cpu_ack_d = (owner_d == OWN_CPU);
                if (owner_d == OWN_CPU) begin
                    n_buf_oe_d = 1'b0;
                    n_we_d     = rw_d;
                end
            end
            PRE: n_vid_ld_d = !(state_q == CAS && owner_q == OWN_VID);
`ifdef DRAM_REFRESH_EN
            CBR_CAS: n_cas_d = 1'b0;
            CBR_RAS: begin
                n_cas_d = 1'b0;
                n_ras_d = 1'b0;
            end
`endif
            default: ;
        endcase
        busy_d    = (state_d != IDLE);
        buf_dir_d = busy_d && owner_d == OWN_CPU && !rw_d;
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state_q    <= IDLE;
            owner_q    <= OWN_CPU;
            rw_q       <= 1'b1;
            lose_q     <= '0;
            pre_cnt_q  <= '0;
            addr_sel_q <= '0;
            vid_ack_q  <= 1'b0;
            snd_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            n_ras_q    <= 1'b1;
            n_cas_q    <= 1'b1;
            row_col_q  <= 1'b0;
            n_we_q     <= 1'b1;
            n_buf_oe_q <= 1'b1;
            buf_dir_q  <= 1'b0;
            n_vid_ld_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef DRAM_REFRESH_EN
            div_q      <= '0;
            ref_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            lose_q     <= lose_d;
            pre_cnt_q  <= pre_cnt_d;
            addr_sel_q <= addr_sel_d;
            vid_ack_q  <= vid_ack_d;
            snd_ack_q  <= snd_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            n_ras_q    <= n_ras_d;
            n_cas_q    <= n_cas_d;
            row_col_q  <= row_col_d;
            n_we_q     <= n_we_d;
            n_buf_oe_q <= n_buf_oe_d;
            buf_dir_q  <= buf_dir_d;
            n_vid_ld_q <= n_vid_ld_d;
            busy_q     <= busy_d;
`ifdef DRAM_REFRESH_EN
            div_q      <= div_d;
            ref_pend_q <= ref_pend_d;
`endif
        end
    end

    assign vid_ack  = vid_ack_q;
    assign snd_ack  = snd_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign n_ras    = n_ras_q;
    assign n_cas    = n_cas_q;
    assign row_col  = row_col_q;
    assign addr_sel = addr_sel_q;
    assign n_we     = n_we_q;
    assign n_buf_oe = n_buf_oe_q;
    assign buf_dir  = buf_dir_q;
    assign n_vid_ld = n_vid_ld_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dram_sched.sv
// tb/tb_dram_sched.sv - self-checking bench for dram_sched against a cycle-offset reference model
module tb_dram_sched;

    localparam int PRE  = 2;
    localparam int MAXW = 2;
    localparam int M_HOLD = 0, M_DROP = 1, M_RAND = 2;
    // {vid_ack,snd_ack,cpu_ack,n_ras,n_cas,row_col,addr_sel[1:0],n_we,n_buf_oe,buf_dir,n_vid_ld,busy}
    localparam logic [12:0] RST_VEC = 13'b000_1_1_0_00_1_1_0_1_0;

    logic       clk = 1'b0;
    logic       n_res;
    logic       vid_req, snd_req, cpu_req, cpu_rw;
    logic       vid_ack, snd_ack, cpu_ack, n_ras, n_cas, row_col;
    logic [1:0] addr_sel;
    logic       n_we, n_buf_oe, buf_dir, n_vid_ld, busy;

    int errors = 0;
    int checks = 0;
    int mode   = M_HOLD;

    int cyc     = 0;
    int m_k     = -1000;
    int m_free  = 0;
    int m_lose  = 0;
    int m_owner = 0;
    int m_addr  = 0;
    bit m_rw    = 1'b1;
    bit m_vack, m_sack, m_cack;
    logic [12:0] m_exp;

    int dut_order[$];
    int exp_order[$];

    dram_sched #(.PRE_CYCLES(PRE), .CPU_MAX_WAIT(MAXW), .REFRESH_DIV(256)) dut (
        .clk(clk), .n_res(n_res),
        .vid_req(vid_req), .snd_req(snd_req), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
        .vid_ack(vid_ack), .snd_ack(snd_ack), .cpu_ack(cpu_ack),
        .n_ras(n_ras), .n_cas(n_cas), .row_col(row_col), .addr_sel(addr_sel),
        .n_we(n_we), .n_buf_oe(n_buf_oe), .buf_dir(buf_dir),
        .n_vid_ld(n_vid_ld), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a grant at edge k fixes the whole access as a function of (edge - k).
    task automatic model_edge();
        int w;
        int off;
        bit act, strobe, cpuc;
        cyc++;
        if (cyc >= m_free) begin
            w = -1;
            if (cpu_req && m_lose == MAXW) w = 0;
            else if (vid_req) w = 1;
            else if (snd_req) w = 2;
            else if (cpu_req) w = 0;
            if (!cpu_req || w == 0) m_lose = 0;
            else if (w > 0 && m_lose < MAXW) m_lose++;
            if (w >= 0) begin
                m_k = cyc; m_free = cyc + 4 + PRE; m_owner = w; m_addr = w; m_rw = cpu_rw;
            end
        end
        off    = cyc - m_k;
        act    = (off >= 0) && (off <= 2 + PRE);
        strobe = act && (off == 1 || off == 2);
        cpuc   = act && m_owner == 0;
        m_vack = act && off == 2 && m_owner == 1;
        m_sack = act && off == 2 && m_owner == 2;
        m_cack = act && off == 2 && m_owner == 0;
        m_exp  = {m_vack, m_sack, m_cack, !(act && off <= 2), !(act && off == 2), strobe,
                  2'(m_addr), !(cpuc && strobe && !m_rw), !(cpuc && strobe), cpuc && !m_rw,
                  !(act && off == 3 && m_owner == 1), act};
    endtask

    task automatic model_reset();
        m_k = -1000; m_free = 0; m_lose = 0; m_addr = 0;
        m_vack = 1'b0; m_sack = 1'b0; m_cack = 1'b0;
    endtask

    task automatic check(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {vid_ack, snd_ack, cpu_ack, n_ras, n_cas, row_col, addr_sel,
               n_we, n_buf_oe, buf_dir, n_vid_ld, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_order(input string tag);
        checks++;
        assert (dut_order.size() == exp_order.size()) else begin
            errors++;
            $error("FAIL %s_count observed=%0d expected=%0d", tag, dut_order.size(), exp_order.size());
        end
        for (int i = 0; i < exp_order.size() && i < dut_order.size(); i++) begin
            checks++;
            assert (dut_order[i] == exp_order[i]) else begin
                errors++;
                $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, dut_order[i], exp_order[i]);
            end
        end
    endtask

    function automatic logic next_req(input logic cur, input bit acked);
        if (acked) return 1'($urandom_range(0, 1));
        if (!cur) return ($urandom_range(0, 3) == 0);
        return cur;
    endfunction

    task automatic edge_check(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, m_exp);
        if (vid_ack === 1'b1) dut_order.push_back(1);
        if (snd_ack === 1'b1) dut_order.push_back(2);
        if (cpu_ack === 1'b1) dut_order.push_back(0);
    endtask

    task automatic cycle(input string tag);
        edge_check(tag);
        @(negedge clk);
        if (mode == M_DROP) begin
            if (m_vack) vid_req = 1'b0;
            if (m_sack) snd_req = 1'b0;
            if (m_cack) cpu_req = 1'b0;
        end else if (mode == M_RAND) begin
            vid_req = next_req(vid_req, m_vack);
            snd_req = next_req(snd_req, m_sack);
            cpu_req = next_req(cpu_req, m_cack);
            cpu_rw  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        n_res = 1'b0; vid_req = 1'b0; snd_req = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 check("reset", RST_VEC);
        end
        @(negedge clk);
        n_res = 1'b1;

        mode = M_DROP; cpu_req = 1'b1; cpu_rw = 1'b0;
        repeat (8) cycle("cpu_write");

        vid_req = 1'b1; snd_req = 1'b1; cpu_req = 1'b1; cpu_rw = 1'b1;
        dut_order.delete();
        repeat (22) cycle("three_way");
        exp_order = '{1, 2, 0};
        check_order("order_three_way");

        mode = M_HOLD; vid_req = 1'b1; cpu_req = 1'b1; snd_req = 1'b0;
        dut_order.delete();
        repeat (36) cycle("starve");
        exp_order = '{1, 1, 0, 1, 1, 0};
        check_order("order_starve");
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (8) cycle("drain");

        cpu_req = 1'b1; cpu_rw = 1'b0;
        repeat (3) edge_check("pre_reset");
        #2 n_res = 1'b0;
        #1 check("reset_mid_cas", RST_VEC);
        model_reset();
        @(negedge clk);
        n_res = 1'b1;
        mode = M_DROP;
        repeat (10) cycle("after_reset");

        mode = M_RAND;
        repeat (400) cycle("random");

        mode = M_HOLD; vid_req = 1'b0; snd_req = 1'b0; cpu_req = 1'b0;
        repeat (1000) cycle("idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
